// File: rtl/iterative_shift_unit.sv
// Multi-cycle 32-bit shifter: one 1-bit step per clock.
// Start/ready handshake; fixed area regardless of distance.
module iterative_shift_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_start,
  input  logic [1:0]  ctrl_shiftop,
  input  logic [4:0]  ctrl_shiftamt,
  input  logic [31:0] data_operandA,
  output logic [31:0] data_result,
  output logic        data_resultRDY,
  output logic        data_busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_SRL = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  state_t      state_q, state_d;
  logic [31:0] work_q, work_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] step;

  // One-bit step of the working register for the latched op
  always_comb begin
    step = work_q;
    unique case (op_q)
      OP_SLL: step = {work_q[30:0], 1'b0};
      OP_SRA: step = {work_q[31], work_q[31:1]};
      OP_SRL: step = {1'b0, work_q[31:1]};
      OP_ROR: step = {work_q[0], work_q[31:1]};
    endcase
  end

  // Next-state and datapath load/step decode
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (ctrl_start) begin
          work_d  = data_operandA;
          op_d    = ctrl_shiftop;
          cnt_d   = ctrl_shiftamt;
          state_d = (ctrl_shiftamt == 5'd0)
                  ? DONE : SHIFT;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        work_d = step;
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd1)
          state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_result    = work_q;
  assign data_busy      = (state_q == SHIFT);
  assign data_resultRDY = (state_q == DONE);

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Directed self-checking bench for iterative_shift_unit.
// Inputs change and outputs are sampled 1 time unit after each edge.
module tb_iterative_shift_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_start;
  logic [1:0]  ctrl_shiftop;
  logic [4:0]  ctrl_shiftamt;
  logic [31:0] data_operandA;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        data_busy;

  int tests = 0;
  int fails = 0;

  iterative_shift_unit dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_start     (ctrl_start),
    .ctrl_shiftop   (ctrl_shiftop),
    .ctrl_shiftamt  (ctrl_shiftamt),
    .data_operandA  (data_operandA),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .data_busy      (data_busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic launch(input logic [1:0] op,
                        input logic [4:0] amt,
                        input logic [31:0] a);
    ctrl_shiftop  = op;
    ctrl_shiftamt = amt;
    data_operandA = a;
    ctrl_start    = 1'b1;
    tick();
    ctrl_start    = 1'b0;
  endtask

  // Bounded wait for RDY; counts cycles and busy cycles seen
  task automatic wait_rdy(output int cyc, output int bsy);
    cyc = 0;
    bsy = 0;
    while (!data_resultRDY && cyc < 40) begin
      if (data_busy) bsy++;
      tick();
      cyc++;
    end
  endtask

  task automatic run(input string tag,
                     input logic [1:0] op,
                     input logic [4:0] amt,
                     input logic [31:0] a,
                     input logic [31:0] exp);
    int cyc, bsy;
    launch(op, amt, a);
    wait_rdy(cyc, bsy);
    chk({tag, "_lat"}, cyc, {27'd0, amt});
    chk({tag, "_busy"}, bsy, {27'd0, amt});
    chk({tag, "_res"}, data_result, exp);
    chk({tag, "_rdy_nobusy"}, data_busy, 0);
    tick();
    chk({tag, "_rdy_pulse"}, data_resultRDY, 0);
    chk({tag, "_hold"}, data_result, exp);
  endtask

  initial begin
    int cyc, bsy, nrdy, first;
    logic [31:0] res;

    reset         = 1'b1;
    ctrl_start    = 1'b1;
    ctrl_shiftop  = 2'b00;
    ctrl_shiftamt = 5'd3;
    data_operandA = 32'hDEADBEEF;
    tick();
    tick();
    chk("rst_result", data_result, 32'h0);
    chk("rst_rdy", data_resultRDY, 0);
    chk("rst_busy", data_busy, 0);
    ctrl_start = 1'b0;
    reset      = 1'b0;
    tick();
    chk("idle_rdy", data_resultRDY, 0);

    run("sra31", 2'b01, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF);
    tick();
    chk("sra31_idle_busy", data_busy, 0);
    chk("sra31_idle_hold", data_result, 32'hFFFF_FFFF);

    run("sll4", 2'b00, 5'd4, 32'h0000_0001, 32'h0000_0010);
    run("srl31", 2'b10, 5'd31, 32'h8000_0000, 32'h0000_0001);
    run("ror4", 2'b11, 5'd4, 32'h0000_000F, 32'hF000_0000);
    run("amt0", 2'b01, 5'd0, 32'h1234_5678, 32'h1234_5678);
    run("sra4", 2'b01, 5'd4, 32'h8000_00F0, 32'hF800_000F);

    // Start reasserted during SHIFT must be dropped
    launch(2'b00, 5'd8, 32'h0000_0001);
    nrdy  = 0;
    first = -1;
    res   = '0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 2) begin
        ctrl_start    = 1'b1;
        ctrl_shiftop  = 2'b10;
        ctrl_shiftamt = 5'd3;
        data_operandA = 32'hFFFF_0000;
      end else begin
        ctrl_start = 1'b0;
      end
      tick();
      if (data_resultRDY) begin
        nrdy++;
        if (first < 0) begin
          first = i;
          res   = data_result;
        end
      end
    end
    ctrl_start = 1'b0;
    chk("ign_nrdy", nrdy, 1);
    chk("ign_lat", first, 8);
    chk("ign_res", res, 32'h0000_0100);

    // Reset on the 5th SHIFT cycle aborts the request
    launch(2'b01, 5'd20, 32'hF000_0000);
    repeat (4) tick();
    chk("abort_busy_pre", data_busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_result", data_result, 32'h0);
    chk("abort_rdy", data_resultRDY, 0);
    chk("abort_busy", data_busy, 0);
    nrdy = 0;
    bsy  = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (data_resultRDY) nrdy++;
      if (data_busy) bsy++;
    end
    chk("abort_no_rdy", nrdy, 0);
    chk("abort_no_busy", bsy, 0);
    run("fresh", 2'b01, 5'd4, 32'hF000_0000, 32'hFF00_0000);

    // Back-to-back: new start accepted at the DONE edge
    launch(2'b10, 5'd2, 32'h0000_0100);
    wait_rdy(cyc, bsy);
    chk("b2b_first_lat", cyc, 2);
    chk("b2b_first_res", data_result, 32'h0000_0040);
    ctrl_shiftop  = 2'b00;
    ctrl_shiftamt = 5'd1;
    data_operandA = 32'h0000_0003;
    ctrl_start    = 1'b1;
    tick();
    ctrl_start    = 1'b0;
    chk("b2b_shift_busy", data_busy, 1);
    chk("b2b_shift_rdy", data_resultRDY, 0);
    tick();
    chk("b2b_second_rdy", data_resultRDY, 1);
    chk("b2b_second_res", data_result, 32'h0000_0006);
    tick();
    chk("b2b_end_rdy", data_resultRDY, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
